// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 exception controller.
//   - CP0 register numbers (COUNT, COMPARE, STATUS, CAUSE, EPC)
//   - ExcCode values written into CAUSE[6:2]
//   - STATUS bit positions
//   - controller FSM state encoding
//   - register packing helpers for MFC0 read-back
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FLUSH_EXC = 2'd1;
    localparam logic [1:0] ST_FLUSH_RET = 2'd2;

    // CAUSE layout: bit15 IP7, bit10 IP2, [6:2] ExcCode, everything else 0.
    function automatic logic [31:0] pack_cause(input logic       ip7,
                                               input logic       ip2,
                                               input logic [4:0] exc_code);
        pack_cause = {16'h0000, ip7, 4'h0, ip2, 3'b000, exc_code, 2'b00};
    endfunction

    // STATUS layout: bit1 EXL, bit0 IE, everything else 0.
    function automatic logic [31:0] pack_status(input logic exl,
                                                input logic ie);
        pack_status = {30'd0, exl, ie};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchronizer bringing the asynchronous external
// interrupt level into the i_clk domain.
// Ports:
//   i_clk    in  clock, rising edge
//   i_rst_n  in  asynchronous active-low reset, clears the chain to 0
//   i_async  in  asynchronous level input
//   o_sync   out synchronized level (last flop of the chain)
// Parameter STAGES is the chain depth and must be at least 2.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] sync_r;

    // Shift the async level through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_r[STAGES-1];

endmodule

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: coprocessor-0 exception sequencer.
// Detects EX overflow, ID reserved instruction and external interrupts,
// records EPC/CAUSE, and issues a one-cycle registered flush plus PC
// redirect. Also services MTC0 writes (with a one-cycle flush), MFC0 reads
// and ERET.
// Ports:
//   i_clk, i_rst_n           clock / async active-low reset
//   i_irq                    external interrupt level (async)
//   i_ovf_ex, i_pc_ex        overflow in EX and its PC
//   i_undef_id, i_pc_id      reserved opcode in ID and ID PC
//   i_mtc0, i_eret           MTC0 / ERET in ID
//   i_cp0_addr, i_cp0_wdata  CP0 register number and MTC0 write data
//   o_exception              flush pulse to IF/ID and ID/EX
//   o_mtc0_flush             flush pulse following a CP0 write
//   o_pc_sel, o_pc_vector    fetch redirect and its target
//   o_cp0_rdata              MFC0 read data (combinational on i_cp0_addr)
//   o_epc                    current EPC
// Optional build macro CP0_COUNT_EN adds COUNT (9) / COMPARE (11) and the
// IP7 timer interrupt; without it those addresses read 0 and IP7 is 0.
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0180,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_irq,
    input  logic        i_ovf_ex,
    input  logic        i_undef_id,
    input  logic [31:0] i_pc_id,
    input  logic [31:0] i_pc_ex,
    input  logic        i_mtc0,
    input  logic        i_eret,
    input  logic [4:0]  i_cp0_addr,
    input  logic [31:0] i_cp0_wdata,
    output logic        o_exception,
    output logic        o_mtc0_flush,
    output logic        o_pc_sel,
    output logic [31:0] o_pc_vector,
    output logic [31:0] o_cp0_rdata,
    output logic [31:0] o_epc
);

    logic [1:0]  state_r, state_d;
    logic        ie_r, ie_d;
    logic        exl_r, exl_d;
    logic [4:0]  exc_code_r, exc_code_d;
    logic [31:0] epc_r, epc_d;
    logic        exception_r, exception_d;
    logic        pc_sel_r, pc_sel_d;
    logic        mtc0_flush_r, mtc0_flush_d;
    logic [31:0] pc_vector_r, pc_vector_d;

    logic        ip2_s;
    logic        ip7_s;
    logic        irq_take_s;
    logic        det_s;
    logic [4:0]  det_code_s;
    logic [31:0] det_epc_s;
    logic        idle_s;
    logic        mtc0_acc_s;

    irq_sync #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_irq),
        .o_sync  (ip2_s)
    );

    assign idle_s = (state_r == ST_IDLE);

    // Exception detection with fixed priority: overflow, reserved, interrupt.
    always_comb begin
        irq_take_s = (ip2_s | ip7_s) & ie_r & ~exl_r;
        if (i_ovf_ex) begin
            det_code_s = EXC_OV;
            det_epc_s  = i_pc_ex;
        end else if (i_undef_id) begin
            det_code_s = EXC_RI;
            det_epc_s  = i_pc_id;
        end else begin
            det_code_s = EXC_INT;
            det_epc_s  = i_pc_id;
        end
        det_s = i_ovf_ex | i_undef_id | irq_take_s;
    end

    // An MTC0 only lands when nothing with higher priority claims the cycle.
    assign mtc0_acc_s = idle_s & ~det_s & ~i_eret & i_mtc0;

    // Next-state, CP0 register update and registered-output next values.
    always_comb begin
        state_d      = state_r;
        ie_d         = ie_r;
        exl_d        = exl_r;
        exc_code_d   = exc_code_r;
        epc_d        = epc_r;
        exception_d  = 1'b0;
        pc_sel_d     = 1'b0;
        mtc0_flush_d = 1'b0;
        pc_vector_d  = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (det_s) begin
                    exc_code_d = det_code_s;
                    // A nested sync exception keeps the original return PC.
                    if (!exl_r) begin
                        epc_d = det_epc_s;
                    end else begin
                        epc_d = epc_r;
                    end
                    exl_d       = 1'b1;
                    state_d     = ST_FLUSH_EXC;
                    exception_d = 1'b1;
                    pc_sel_d    = 1'b1;
                    pc_vector_d = EXC_VECTOR;
                end else if (i_eret) begin
                    exl_d       = 1'b0;
                    state_d     = ST_FLUSH_RET;
                    exception_d = 1'b1;
                    pc_sel_d    = 1'b1;
                    pc_vector_d = epc_r;
                end else if (mtc0_acc_s) begin
                    mtc0_flush_d = 1'b1;
                    case (i_cp0_addr)
                        CP0_STATUS: begin
                            ie_d  = i_cp0_wdata[STATUS_IE];
                            exl_d = i_cp0_wdata[STATUS_EXL];
                        end
                        CP0_CAUSE: begin
                            exc_code_d = i_cp0_wdata[6:2];
                        end
                        CP0_EPC: begin
                            epc_d = i_cp0_wdata;
                        end
                        default: begin
                            // COUNT/COMPARE live elsewhere; others are unmapped.
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_EXC, ST_FLUSH_RET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, CP0 registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            ie_r         <= 1'b0;
            exl_r        <= 1'b0;
            exc_code_r   <= 5'd0;
            epc_r        <= 32'd0;
            exception_r  <= 1'b0;
            pc_sel_r     <= 1'b0;
            mtc0_flush_r <= 1'b0;
            pc_vector_r  <= 32'd0;
        end else begin
            state_r      <= state_d;
            ie_r         <= ie_d;
            exl_r        <= exl_d;
            exc_code_r   <= exc_code_d;
            epc_r        <= epc_d;
            exception_r  <= exception_d;
            pc_sel_r     <= pc_sel_d;
            mtc0_flush_r <= mtc0_flush_d;
            pc_vector_r  <= pc_vector_d;
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        ip7_r;

    // Free-running COUNT, COMPARE and the sticky IP7 timer request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            ip7_r     <= 1'b0;
        end else begin
            if (mtc0_acc_s && (i_cp0_addr == CP0_COUNT)) begin
                count_r <= i_cp0_wdata;
            end else begin
                count_r <= count_r + 32'd1;
            end
            // Writing COMPARE acknowledges the timer, beating a same-cycle match.
            if (mtc0_acc_s && (i_cp0_addr == CP0_COMPARE)) begin
                compare_r <= i_cp0_wdata;
                ip7_r     <= 1'b0;
            end else if (count_r == compare_r) begin
                ip7_r <= 1'b1;
            end else begin
                ip7_r <= ip7_r;
            end
        end
    end

    assign ip7_s = ip7_r;
`else
    assign ip7_s = 1'b0;
`endif

    // MFC0 read mux; unmapped addresses read 0.
    always_comb begin
        case (i_cp0_addr)
            CP0_STATUS: o_cp0_rdata = pack_status(exl_r, ie_r);
            CP0_CAUSE:  o_cp0_rdata = pack_cause(ip7_s, ip2_s, exc_code_r);
            CP0_EPC:    o_cp0_rdata = epc_r;
`ifdef CP0_COUNT_EN
            CP0_COUNT:   o_cp0_rdata = count_r;
            CP0_COMPARE: o_cp0_rdata = compare_r;
`else
            CP0_COUNT, CP0_COMPARE: o_cp0_rdata = 32'd0;
`endif
            default:    o_cp0_rdata = 32'd0;
        endcase
    end

    assign o_exception  = exception_r;
    assign o_pc_sel     = pc_sel_r;
    assign o_mtc0_flush = mtc0_flush_r;
    assign o_pc_vector  = pc_vector_r;
    assign o_epc        = epc_r;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: self-checking bench for cp0_exception_ctrl
// (default build, CP0_COUNT_EN undefined). A cycle-level reference model
// kept in plain variables predicts outputs, CP0 registers and MFC0 data;
// directed sequences cover the main scenarios, then randomized traffic runs.
module tb_cp0_exception_ctrl;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic        ovf;
    logic        undef;
    logic [31:0] pc_id;
    logic [31:0] pc_ex;
    logic        mtc0;
    logic        eret;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exc_o;
    logic        mflush_o;
    logic        sel_o;
    logic [31:0] vec_o;
    logic [31:0] rdata_o;
    logic [31:0] epc_o;

    int checks;
    int errors;

    // reference model state
    logic        m_ie;
    logic        m_exl;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic        e_exc;
    logic        e_sel;
    logic        e_mflush;
    logic [31:0] e_vec;
    bit          irq_q[$];

    cp0_exception_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_irq        (irq),
        .i_ovf_ex     (ovf),
        .i_undef_id   (undef),
        .i_pc_id      (pc_id),
        .i_pc_ex      (pc_ex),
        .i_mtc0       (mtc0),
        .i_eret       (eret),
        .i_cp0_addr   (addr),
        .i_cp0_wdata  (wdata),
        .o_exception  (exc_o),
        .o_mtc0_flush (mflush_o),
        .o_pc_sel     (sel_o),
        .o_pc_vector  (vec_o),
        .o_cp0_rdata  (rdata_o),
        .o_epc        (epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 1'b0; m_exl = 1'b0; m_code = 5'd0; m_epc = 32'd0;
        e_exc = 1'b0; e_sel = 1'b0; e_mflush = 1'b0; e_vec = 32'd0;
        irq_q.delete();
    endtask

    // irq level seen by CP0 logic: the input as driven two clock edges back
    function automatic bit synced_irq();
        if (irq_q.size() >= 2) return irq_q[irq_q.size()-2];
        return 1'b0;
    endfunction

    // Advance the model by one rising edge using the inputs now driven.
    task automatic model_edge();
        bit       busy;
        bit       ip2;
        logic [4:0] code;
        busy = e_exc;
        ip2  = synced_irq();
        irq_q.push_back(irq);
        if (irq_q.size() > 4) void'(irq_q.pop_front());
        e_exc = 1'b0; e_sel = 1'b0; e_mflush = 1'b0; e_vec = 32'd0;
        if (!busy) begin
            if (ovf || undef || (ip2 && m_ie && !m_exl)) begin
                code = ovf ? 5'd12 : (undef ? 5'd10 : 5'd0);
                if (!m_exl) m_epc = ovf ? pc_ex : pc_id;
                m_code = code;
                m_exl = 1'b1;
                e_exc = 1'b1; e_sel = 1'b1; e_vec = 32'h0000_0180;
            end else if (eret) begin
                m_exl = 1'b0;
                e_exc = 1'b1; e_sel = 1'b1; e_vec = m_epc;
            end else if (mtc0) begin
                e_mflush = 1'b1;
                if (addr == 5'd12) begin
                    m_ie  = wdata[0];
                    m_exl = wdata[1];
                end else if (addr == 5'd13) begin
                    m_code = 5'((wdata >> 2) & 32'd31);
                end else if (addr == 5'd14) begin
                    m_epc = wdata;
                end
            end
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return 32'(m_exl) * 32'd2 + 32'(m_ie);
            5'd13:   return 32'(m_code) * 32'd4 + (synced_irq() ? 32'd1024 : 32'd0);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        model_edge();
        @(negedge clk);
        check_val("o_exception",  {31'd0, exc_o},    {31'd0, e_exc});
        check_val("o_pc_sel",     {31'd0, sel_o},    {31'd0, e_sel});
        check_val("o_mtc0_flush", {31'd0, mflush_o}, {31'd0, e_mflush});
        check_val("o_pc_vector",  vec_o,  e_vec);
        check_val("o_epc",        epc_o,  m_epc);
        check_val("o_cp0_rdata",  rdata_o, model_rdata(addr));
    endtask

    task automatic quiet();
        ovf = 1'b0; undef = 1'b0; mtc0 = 1'b0; eret = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check_val(tag, rdata_o, exp);
    endtask

    task automatic rand_inputs();
        ovf   = ($urandom_range(0, 99) < 6);
        undef = ($urandom_range(0, 99) < 6);
        eret  = ($urandom_range(0, 99) < 10);
        mtc0  = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 99) < 10) irq = ~irq;
        pc_id = $urandom;
        pc_ex = $urandom;
        wdata = $urandom;
        case ($urandom_range(0, 5))
            0: addr = 5'd9;
            1: addr = 5'd11;
            2: addr = 5'd12;
            3: addr = 5'd13;
            4: addr = 5'd14;
            default: addr = 5'($urandom_range(0, 31));
        endcase
    endtask

    initial begin
        bit seen;
        checks = 0; errors = 0;
        rst_n = 1'b0; irq = 1'b0; quiet();
        pc_id = 32'd0; pc_ex = 32'd0; addr = 5'd0; wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_exception", {31'd0, exc_o}, 32'd0);
        check_val("rst_vector", vec_o, 32'd0);
        check_val("rst_epc", epc_o, 32'd0);
        rst_n = 1'b1;
        step();

        // overflow from clean state
        pc_ex = 32'h0000_0040; ovf = 1'b1; addr = 5'd13;
        step();
        quiet();
        check_val("ovf_exception", {31'd0, exc_o}, 32'd1);
        check_val("ovf_vector", vec_o, 32'h0000_0180);
        check_val("ovf_epc", epc_o, 32'h0000_0040);
        read_reg("ovf_cause", 5'd13, 32'h0000_0030);
        read_reg("ovf_status", 5'd12, 32'h0000_0002);
        step();

        // clear STATUS, then irq held high with IE=0 must be ignored
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'd0;
        step();
        quiet(); irq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("irq_masked", {31'd0, exc_o}, 32'd0);
        end

        // enable interrupts: flush pulse, then exception within 4 cycles
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'd1;
        step();
        check_val("mtc0_flush", {31'd0, mflush_o}, 32'd1);
        quiet(); pc_id = 32'h0000_0200;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (exc_o) seen = 1'b1;
        end
        check_val("irq_taken", {31'd0, seen}, 32'd1);
        check_val("irq_epc", epc_o, 32'h0000_0200);
        read_reg("irq_cause", 5'd13, 32'h0000_0400);
        read_reg("irq_status", 5'd12, 32'h0000_0003);
        irq = 1'b0;
        repeat (4) step();

        // ERET back to EPC=0x100
        mtc0 = 1'b1; addr = 5'd14; wdata = 32'h0000_0100;
        step();
        quiet(); eret = 1'b1; addr = 5'd12;
        step();
        quiet();
        check_val("eret_exception", {31'd0, exc_o}, 32'd1);
        check_val("eret_vector", vec_o, 32'h0000_0100);
        read_reg("eret_status", 5'd12, 32'h0000_0001);
        step();
        check_val("eret_one_cycle", {31'd0, exc_o}, 32'd0);

        // simultaneous ovf/undef/mtc0: overflow wins, STATUS write dropped
        mtc0 = 1'b1; addr = 5'd12; wdata = 32'd0;
        step();
        ovf = 1'b1; undef = 1'b1; mtc0 = 1'b1; addr = 5'd12; wdata = 32'd3;
        pc_ex = 32'h0000_0044; pc_id = 32'h0000_0048;
        step();
        quiet();
        check_val("sim_mflush", {31'd0, mflush_o}, 32'd0);
        check_val("sim_epc", epc_o, 32'h0000_0044);
        read_reg("sim_cause", 5'd13, 32'h0000_0030);
        read_reg("sim_status", 5'd12, 32'h0000_0002);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        // drain to idle with interrupts disabled, then reset mid-flush
        quiet(); irq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mtc0 = 1'b1; addr = 5'd12; wdata = 32'd0;
            step();
        end
        quiet(); ovf = 1'b1; pc_ex = 32'h0000_0080;
        step();
        quiet();
        check_val("pre_rst_exception", {31'd0, exc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_exception", {31'd0, exc_o}, 32'd0);
        check_val("rst_mid_pc_sel", {31'd0, sel_o}, 32'd0);
        check_val("rst_mid_vector", vec_o, 32'd0);
        check_val("rst_mid_mflush", {31'd0, mflush_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        read_reg("post_rst_status", 5'd12, 32'd0);
        read_reg("post_rst_cause", 5'd13, 32'd0);
        read_reg("post_rst_epc", 5'd14, 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
